fetch_queue: RTL

Parametrised instruction-fetch front end for the next-generation CPU core. It replaces the bare PC register plus instruction-memory pairing with a PC generator, a single-outstanding request port to synchronous instruction memory, and a DEPTH-entry prefetch FIFO. It feeds the decoder with an instruction and its address through a valid/ready handshake. It supports redirects (branches/jumps) with flush of buffered and in-flight fetches, and it stops issuing on halt.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding imem port, DEPTH-entry prefetch FIFO.
// Optional macro FETCH_BYPASS_EN presents a response straight to the decoder when the FIFO is empty.
module fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hlt,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_addr,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [LVL_W-1:0]   count_reg;
  logic [LVL_W-1:0]   count_next;
  logic               inflight_reg;
  logic [ADDR_W-1:0]  inflight_addr_reg;

  logic               kill;
  logic               resp_valid;
  logic               bypass;
  logic               pop;
  logic               fifo_pop;
  logic               wr_en;
  logic [LVL_W:0]     occupancy;

  // A response landing in a redirect cycle belongs to the squashed path.
  assign kill       = redirect;
  assign resp_valid = inflight_reg && !kill && !rst;

  // Reserve a slot for the outstanding request so the FIFO can never overflow.
  assign occupancy = {1'b0, count_reg} + {{LVL_W{1'b0}}, inflight_reg};
  assign imem_req  = !rst && !hlt && !redirect && (occupancy < (LVL_W+1)'(DEPTH));
  assign imem_addr = fetch_pc_reg;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_valid && (count_reg == '0);
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = (count_reg != '0) || bypass;
  assign instr       = bypass ? imem_rdata : instr_mem[rd_ptr_reg];
  assign instr_addr  = bypass ? inflight_addr_reg : addr_mem[rd_ptr_reg];
  assign level       = count_reg;

  assign pop      = instr_valid && instr_ready && !redirect;
  assign fifo_pop = pop && !bypass;
  assign wr_en    = resp_valid && !(bypass && instr_ready);

  always_comb begin
    count_next = count_reg;
    case ({wr_en, fifo_pop})
      2'b10:   count_next = count_reg + LVL_W'(1);
      2'b01:   count_next = count_reg - LVL_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg      <= RESET_PC;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_addr;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc_reg      <= fetch_pc_reg + ADDR_W'(1);
        inflight_addr_reg <= fetch_pc_reg;
      end
      inflight_reg <= imem_req;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else if (wr_en) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      addr_mem[wr_ptr_reg]  <= inflight_addr_reg;
    end
  end

endmodule
